// File: rtl/rep_string_sequencer_pkg.sv
// Shared encodings for the string-instruction iteration controller.
package rep_string_sequencer_pkg;

  // Bit positions inside the one-hot opc field.
  localparam int CMD_MOVS = 0;
  localparam int CMD_CMPS = 1;
  localparam int CMD_SCAS = 2;
  localparam int CMD_STOS = 3;
  localparam int CMD_LODS = 4;

  localparam logic [5:0] STRING_CMD_MASK = 6'b011111;

  localparam logic [1:0] REP_NONE = 2'b00;
  localparam logic [1:0] REP_E    = 2'b01;
  localparam logic [1:0] REP_NE   = 2'b10;

  localparam logic [1:0] WIDTH_BYTE  = 2'b00;
  localparam logic [1:0] WIDTH_WORD  = 2'b01;
  localparam logic [1:0] WIDTH_DWORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    UPDATE,
    FIN
  } state_t;

  // A string command has exactly one bit set, and that bit is one of the
  // five string command positions.
  function automatic logic is_string_cmd(input logic [5:0] opc);
    return (opc != 6'd0) && ((opc & (opc - 6'd1)) == 6'd0) &&
           ((opc & ~STRING_CMD_MASK) == 6'd0);
  endfunction

  // Pointer step in bytes for an element width; the unused code steps as dword.
  function automatic logic [31:0] step_bytes(input logic [1:0] width_sel);
    case (width_sel)
      WIDTH_BYTE: return 32'd1;
      WIDTH_WORD: return 32'd2;
      default:    return 32'd4;
    endcase
  endfunction

endpackage

// File: rtl/rep_string_sequencer_step_calc.sv
// string_step_calc: next ESI/EDI/ECX for one completed string iteration.
module string_step_calc
  import rep_string_sequencer_pkg::*;
(
  input  logic [5:0]  opc,
  input  logic [1:0]  width_sel,
  input  logic        df,
  input  logic [31:0] esi,
  input  logic [31:0] edi,
  input  logic [31:0] ecx,
  input  logic [1:0]  rep_kind,
  output logic [31:0] esi_next,
  output logic [31:0] edi_next,
  output logic [31:0] ecx_next,
  output logic        ecx_zero
);

  logic [31:0] step;
  logic [31:0] delta;
  logic        uses_esi;
  logic        uses_edi;

  // Pointer and count stepping; pointers wrap mod 2^32 by plain 32-bit math.
  always_comb begin
    step     = step_bytes(width_sel);
    delta    = df ? (~step + 32'd1) : step;
    uses_esi = opc[CMD_MOVS] | opc[CMD_CMPS] | opc[CMD_LODS];
    uses_edi = opc[CMD_MOVS] | opc[CMD_CMPS] | opc[CMD_STOS] | opc[CMD_SCAS];
    esi_next = uses_esi ? (esi + delta) : esi;
    edi_next = uses_edi ? (edi + delta) : edi;
    ecx_next = (rep_kind != REP_NONE) ? (ecx - 32'd1) : ecx;
    ecx_zero = (ecx_next == 32'd0);
  end

endmodule

// File: rtl/rep_string_sequencer.sv
// Iteration controller for MOVS/CMPS/SCAS/STOS/LODS with optional REP prefixes.
//
//   state  | meaning
//   IDLE   | waiting for start; result registers held
//   ISSUE  | offering ESI/EDI of the current iteration to operand decode
//   WAIT   | iteration accepted, waiting for execute to finish
//   UPDATE | step ESI/EDI/ECX, evaluate termination
//   FIN    | one-cycle done pulse
module rep_string_sequencer
  import rep_string_sequencer_pkg::*;
#(
  parameter int MAX_ITERS = 4096,
  parameter int CNT_W     = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  opc,
  input  logic [1:0]  rep_kind,
  input  logic [1:0]  width_sel,
  input  logic        df,
  input  logic [31:0] ecx_in,
  input  logic [31:0] esi_in,
  input  logic [31:0] edi_in,
  output logic        iter_valid,
  input  logic        iter_ready,
  output logic [31:0] iter_esi,
  output logic [31:0] iter_edi,
  input  logic        exec_done,
  input  logic        exec_zf,
  output logic [31:0] ecx_out,
  output logic [31:0] esi_out,
  output logic [31:0] edi_out,
  output logic        busy,
  output logic        done,
  output logic        err_overrun
);

  state_t state, next_state;

  logic [5:0]       opc_r;
  logic [1:0]       rep_r;
  logic [1:0]       width_r;
  logic             df_r;
  logic             zf_r;
  logic [31:0]      esi_r;
  logic [31:0]      edi_r;
  logic [31:0]      ecx_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc;

  logic [31:0] esi_nx;
  logic [31:0] edi_nx;
  logic [31:0] ecx_nx;
  logic        ecx_zero;

  logic [1:0] rep_in_norm;
  logic       accept;
  logic       zf_cmd;
  logic       cnt_hit;
  logic       last_iter;

  // The reserved prefix code behaves as no prefix.
  assign rep_in_norm = ((rep_kind == REP_E) || (rep_kind == REP_NE)) ? rep_kind : REP_NONE;
  assign accept      = (state == IDLE) && start;
  assign zf_cmd      = opc_r[CMD_CMPS] | opc_r[CMD_SCAS];
  assign cnt_inc     = cnt_r + CNT_W'(1);
  assign cnt_hit     = (cnt_inc == CNT_W'(MAX_ITERS));
  assign last_iter   = (rep_r == REP_NONE) || ecx_zero ||
                       (zf_cmd && (rep_r == REP_E)  && !zf_r) ||
                       (zf_cmd && (rep_r == REP_NE) &&  zf_r) ||
                       cnt_hit;

  assign iter_valid = (state == ISSUE);
  assign busy       = (state != IDLE);
  assign done       = (state == FIN);
  assign iter_esi   = esi_r;
  assign iter_edi   = edi_r;

  string_step_calc u_step (
    .opc       (opc_r),
    .width_sel (width_r),
    .df        (df_r),
    .esi       (esi_r),
    .edi       (edi_r),
    .ecx       (ecx_r),
    .rep_kind  (rep_r),
    .esi_next  (esi_nx),
    .edi_next  (edi_nx),
    .ecx_next  (ecx_nx),
    .ecx_zero  (ecx_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (!is_string_cmd(opc))                           next_state = FIN;
          else if ((rep_in_norm != REP_NONE) && (ecx_in == 32'd0)) next_state = FIN;
          else                                               next_state = ISSUE;
        end
      end
      ISSUE:   if (iter_ready) next_state = WAIT;
      WAIT:    if (exec_done)  next_state = UPDATE;
      UPDATE:  next_state = last_iter ? FIN : ISSUE;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Context latch at start, ZF capture, and per-iteration register stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opc_r       <= '0;
      rep_r       <= REP_NONE;
      width_r     <= '0;
      df_r        <= 1'b0;
      zf_r        <= 1'b0;
      esi_r       <= '0;
      edi_r       <= '0;
      ecx_r       <= '0;
      cnt_r       <= '0;
      esi_out     <= '0;
      edi_out     <= '0;
      ecx_out     <= '0;
      err_overrun <= 1'b0;
    end else begin
      if (accept) begin
        opc_r       <= opc;
        rep_r       <= rep_in_norm;
        width_r     <= width_sel;
        df_r        <= df;
        esi_r       <= esi_in;
        edi_r       <= edi_in;
        ecx_r       <= ecx_in;
        cnt_r       <= '0;
        err_overrun <= 1'b0;
      end
      if ((state == WAIT) && exec_done) zf_r <= exec_zf;
      if (state == UPDATE) begin
        esi_r   <= esi_nx;
        edi_r   <= edi_nx;
        ecx_r   <= ecx_nx;
        esi_out <= esi_nx;
        edi_out <= edi_nx;
        ecx_out <= ecx_nx;
        cnt_r   <= cnt_inc;
        if (cnt_hit) err_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rep_string_sequencer.sv
// Self-checking bench for rep_string_sequencer against a behavioural model.
module tb_rep_string_sequencer;
  import rep_string_sequencer_pkg::*;

  localparam int MAX_IT = 4096;
  localparam logic [5:0] OP_MOVS = 6'(1 << CMD_MOVS);
  localparam logic [5:0] OP_CMPS = 6'(1 << CMD_CMPS);
  localparam logic [5:0] OP_SCAS = 6'(1 << CMD_SCAS);
  localparam logic [5:0] OP_STOS = 6'(1 << CMD_STOS);
  localparam logic [5:0] OP_LODS = 6'(1 << CMD_LODS);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [5:0] opc = '0;
  logic [1:0] rep_kind = '0, width_sel = '0;
  logic df = 1'b0;
  logic [31:0] ecx_in = '0, esi_in = '0, edi_in = '0;
  logic iter_valid, iter_ready = 1'b0;
  logic [31:0] iter_esi, iter_edi;
  logic exec_done = 1'b0, exec_zf = 1'b0;
  logic [31:0] ecx_out, esi_out, edi_out;
  logic busy, done, err_overrun;

  always #5 clk = ~clk;

  rep_string_sequencer #(.MAX_ITERS(MAX_IT), .CNT_W(13)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opc(opc), .rep_kind(rep_kind),
    .width_sel(width_sel), .df(df), .ecx_in(ecx_in), .esi_in(esi_in), .edi_in(edi_in),
    .iter_valid(iter_valid), .iter_ready(iter_ready), .iter_esi(iter_esi), .iter_edi(iter_edi),
    .exec_done(exec_done), .exec_zf(exec_zf), .ecx_out(ecx_out), .esi_out(esi_out),
    .edi_out(edi_out), .busy(busy), .done(done), .err_overrun(err_overrun)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Observations from the last run.
  logic [31:0] q_esi[$], q_edi[$];
  int n_iter, lat_first, lat_bad, unstable, done_bad;
  bit timed_out;
  bit zf_seq[64];

  // Model results.
  logic [31:0] eq_esi[$], eq_edi[$];
  int exp_n;
  bit exp_ovr;
  logic [31:0] m_esi = '0, m_edi = '0, m_ecx = '0;

  // Architectural meaning of a string instruction, iteration by iteration.
  task automatic model(input logic [5:0] o, input logic [1:0] r, input logic [1:0] w,
                       input logic d, input logic [31:0] c, input logic [31:0] si,
                       input logic [31:0] di);
    int rr, step;
    bit is_str, use_si, use_di, is_cmp, stop, zf;
    logic [31:0] s, t, k;
    rr = (r == 2'b11) ? 0 : int'(r);
    is_str = (o == OP_MOVS) || (o == OP_CMPS) || (o == OP_SCAS) || (o == OP_STOS) || (o == OP_LODS);
    use_si = (o == OP_MOVS) || (o == OP_CMPS) || (o == OP_LODS);
    use_di = (o == OP_MOVS) || (o == OP_CMPS) || (o == OP_STOS) || (o == OP_SCAS);
    is_cmp = (o == OP_CMPS) || (o == OP_SCAS);
    step = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    exp_n = 0; exp_ovr = 0;
    eq_esi.delete(); eq_edi.delete();
    if (!is_str || (rr != 0 && c == 0)) return;
    s = si; t = di; k = c;
    stop = 0;
    while (!stop) begin
      eq_esi.push_back(s); eq_edi.push_back(t);
      zf = zf_seq[exp_n % 64];
      if (use_si) s = d ? s - 32'(step) : s + 32'(step);
      if (use_di) t = d ? t - 32'(step) : t + 32'(step);
      if (rr != 0) k = k - 1;
      exp_n++;
      stop = (rr == 0) || (k == 0) || (is_cmp && rr == 1 && !zf) || (is_cmp && rr == 2 && zf);
      if (exp_n == MAX_IT) begin exp_ovr = 1; stop = 1; end
    end
    m_esi = s; m_edi = t; m_ecx = k;
  endtask

  // Drives one instruction and plays operand decode / execute until done.
  task automatic run_op(input logic [5:0] o, input logic [1:0] r, input logic [1:0] w,
                        input logic d, input logic [31:0] c, input logic [31:0] si,
                        input logic [31:0] di, input int stall, input bit poke_start);
    int wc, lat;
    bit fin;
    logic [31:0] a, b;
    q_esi.delete(); q_edi.delete();
    n_iter = 0; lat_first = -1; lat_bad = 0; unstable = 0; done_bad = 0; timed_out = 0;
    @(negedge clk);
    opc = o; rep_kind = r; width_sel = w; df = d; ecx_in = c; esi_in = si; edi_in = di;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; fin = 0;
    while (!fin) begin
      wc = 0;
      while (!(iter_valid || done) && wc < 64) begin @(negedge clk); lat++; wc++; end
      if (!(iter_valid || done) || n_iter > MAX_IT + 8) begin
        timed_out = 1; fin = 1;
      end else begin
        if (n_iter == 0) lat_first = lat;
        else if (lat != 2) lat_bad++;
        if (done) begin
          fin = 1;
          @(negedge clk);
          if (done || busy) done_bad = 1;
        end else begin
          a = iter_esi; b = iter_edi;
          q_esi.push_back(a); q_edi.push_back(b);
          for (int i = 0; i < stall; i++) begin
            if (poke_start && i == 0) begin
              start = 1'b1; esi_in = ~si; edi_in = ~di; ecx_in = 32'd0; opc = 6'h20;
            end
            @(negedge clk);
            start = 1'b0;
            if (!iter_valid || iter_esi !== a || iter_edi !== b) unstable++;
          end
          iter_ready = 1'b1;
          @(negedge clk);
          iter_ready = 1'b0;
          repeat ($urandom_range(0, 2)) @(negedge clk);
          exec_done = 1'b1; exec_zf = zf_seq[n_iter % 64];
          @(negedge clk);
          exec_done = 1'b0;
          lat = 1; n_iter++;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({iter_valid, busy, done, err_overrun} !== 4'b0 || ecx_out !== 0 || esi_out !== 0 ||
        edi_out !== 0 || iter_esi !== 0 || iter_edi !== 0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b busy=%b done=%b ovr=%b ecx=%h esi=%h edi=%h, required all 0",
               iter_valid, busy, done, err_overrun, ecx_out, esi_out, edi_out);
    end
    rst_n = 1'b1;
    m_esi = 0; m_edi = 0; m_ecx = 0;
  endtask

  task automatic test_movs_single;
    foreach (zf_seq[i]) zf_seq[i] = 0;
    model(OP_MOVS, REP_NONE, WIDTH_DWORD, 0, 32'h55, 32'h1000, 32'h2000);
    run_op(OP_MOVS, REP_NONE, WIDTH_DWORD, 0, 32'h55, 32'h1000, 32'h2000, 0, 0);
    n_checks++;
    if (n_iter !== 1 || timed_out) begin n_fail++; $display("FAIL movs_iters: got %0d timeout=%0d, required 1", n_iter, timed_out); end
    n_checks++;
    if (esi_out !== 32'h1004 || edi_out !== 32'h2004) begin n_fail++; $display("FAIL movs_ptrs: esi=%h edi=%h, required 00001004 00002004", esi_out, edi_out); end
    n_checks++;
    if (ecx_out !== 32'h55) begin n_fail++; $display("FAIL movs_ecx: got %h, required 00000055", ecx_out); end
    n_checks++;
    if (lat_first !== 1 || lat_bad != 0 || done_bad != 0) begin n_fail++; $display("FAIL movs_latency: first=%0d bad=%0d donebad=%0d, required 1 0 0", lat_first, lat_bad, done_bad); end
  endtask

  task automatic test_rep_stos;
    model(OP_STOS, REP_E, WIDTH_BYTE, 1, 32'd3, 32'h7, 32'h10);
    run_op(OP_STOS, REP_E, WIDTH_BYTE, 1, 32'd3, 32'h7, 32'h10, 1, 0);
    n_checks++;
    if (n_iter !== 3 || q_edi.size() != 3) begin n_fail++; $display("FAIL stos_iters: got %0d, required 3", n_iter); end
    else begin
      n_checks++;
      if (q_edi[0] !== 32'h10 || q_edi[1] !== 32'h0F || q_edi[2] !== 32'h0E) begin
        n_fail++; $display("FAIL stos_addrs: got %h %h %h, required 10 0f 0e", q_edi[0], q_edi[1], q_edi[2]);
      end
    end
    n_checks++;
    if (edi_out !== 32'h0D || ecx_out !== 32'h0 || esi_out !== 32'h7) begin
      n_fail++; $display("FAIL stos_final: edi=%h ecx=%h esi=%h, required 0000000d 0 7", edi_out, ecx_out, esi_out);
    end
    n_checks++;
    if (lat_bad != 0) begin n_fail++; $display("FAIL stos_latency: %0d bad exec_done latencies, required 0", lat_bad); end
  endtask

  task automatic test_repe_cmps;
    foreach (zf_seq[i]) zf_seq[i] = 1;
    zf_seq[2] = 0;
    model(OP_CMPS, REP_E, WIDTH_WORD, 0, 32'd5, 32'h100, 32'h200);
    run_op(OP_CMPS, REP_E, WIDTH_WORD, 0, 32'd5, 32'h100, 32'h200, 0, 0);
    n_checks++;
    if (n_iter !== 3) begin n_fail++; $display("FAIL cmps_iters: got %0d, required 3", n_iter); end
    n_checks++;
    if (ecx_out !== 32'd2 || esi_out !== 32'h106 || edi_out !== 32'h206) begin
      n_fail++; $display("FAIL cmps_final: ecx=%h esi=%h edi=%h, required 2 106 206", ecx_out, esi_out, edi_out);
    end
  endtask

  task automatic test_zero_count;
    model(OP_LODS, REP_E, WIDTH_DWORD, 0, 32'd0, 32'hAAAA, 32'hBBBB);
    run_op(OP_LODS, REP_E, WIDTH_DWORD, 0, 32'd0, 32'hAAAA, 32'hBBBB, 0, 0);
    n_checks++;
    if (n_iter !== 0 || lat_first !== 1 || done_bad != 0 || timed_out) begin
      n_fail++; $display("FAIL zero_count: iters=%0d done_lat=%0d donebad=%0d, required 0 1 0", n_iter, lat_first, done_bad);
    end
    n_checks++;
    if (ecx_out !== 32'd2 || esi_out !== 32'h106 || edi_out !== 32'h206) begin
      n_fail++; $display("FAIL zero_count_hold: ecx=%h esi=%h edi=%h, required 2 106 206", ecx_out, esi_out, edi_out);
    end
  endtask

  task automatic test_wrap_and_stall;
    model(OP_MOVS, REP_E, WIDTH_BYTE, 0, 32'd2, 32'hFFFF_FFFF, 32'h300);
    run_op(OP_MOVS, REP_E, WIDTH_BYTE, 0, 32'd2, 32'hFFFF_FFFF, 32'h300, 4, 1);
    n_checks++;
    if (esi_out !== 32'h1 || edi_out !== 32'h302 || ecx_out !== 32'h0) begin
      n_fail++; $display("FAIL wrap: esi=%h edi=%h ecx=%h, required 00000001 00000302 0", esi_out, edi_out, ecx_out);
    end
    n_checks++;
    if (unstable != 0 || n_iter !== 2) begin
      n_fail++; $display("FAIL stall_stable: unstable=%0d iters=%0d, required 0 2", unstable, n_iter);
    end
  endtask

  task automatic test_random;
    logic [5:0] ops[7];
    logic [5:0] o; logic [1:0] r, w; logic d; logic [31:0] c, si, di;
    int addr_bad;
    ops = '{OP_MOVS, OP_CMPS, OP_SCAS, OP_STOS, OP_LODS, 6'h20, 6'h03};
    for (int it = 0; it < 30; it++) begin
      foreach (zf_seq[i]) zf_seq[i] = 1'($urandom);
      o = ops[$urandom_range(0, 6)];
      r = 2'($urandom_range(0, 3)); w = 2'($urandom_range(0, 2)); d = 1'($urandom);
      c = $urandom_range(0, 5); si = $urandom; di = $urandom;
      model(o, r, w, d, c, si, di);
      run_op(o, r, w, d, c, si, di, $urandom_range(0, 2), 0);
      n_checks++;
      if (n_iter !== exp_n || timed_out) begin n_fail++; $display("FAIL rand_iters[%0d]: got %0d, required %0d", it, n_iter, exp_n); end
      n_checks++;
      if (esi_out !== m_esi || edi_out !== m_edi || ecx_out !== m_ecx || err_overrun !== 1'b0) begin
        n_fail++; $display("FAIL rand_final[%0d]: esi=%h edi=%h ecx=%h ovr=%b, required %h %h %h 0",
                           it, esi_out, edi_out, ecx_out, err_overrun, m_esi, m_edi, m_ecx);
      end
      addr_bad = (q_esi.size() != eq_esi.size()) ? 1 : 0;
      if (addr_bad == 0)
        foreach (q_esi[i]) if (q_esi[i] !== eq_esi[i] || q_edi[i] !== eq_edi[i]) addr_bad++;
      n_checks++;
      if (addr_bad != 0) begin n_fail++; $display("FAIL rand_addrs[%0d]: %0d address mismatches, required 0", it, addr_bad); end
      n_checks++;
      if (lat_bad != 0 || done_bad != 0 || (exp_n > 0 && lat_first != 1)) begin
        n_fail++; $display("FAIL rand_latency[%0d]: bad=%0d donebad=%0d first=%0d, required 0 0 1", it, lat_bad, done_bad, lat_first);
      end
    end
  endtask

  task automatic test_overrun_and_reset;
    int wc;
    foreach (zf_seq[i]) zf_seq[i] = 0;
    model(OP_STOS, REP_E, WIDTH_DWORD, 0, 32'h10000, 32'h0, 32'h4000);
    run_op(OP_STOS, REP_E, WIDTH_DWORD, 0, 32'h10000, 32'h0, 32'h4000, 0, 0);
    n_checks++;
    if (n_iter !== MAX_IT || exp_n != MAX_IT || timed_out) begin n_fail++; $display("FAIL overrun_iters: got %0d, required %0d", n_iter, MAX_IT); end
    n_checks++;
    if (err_overrun !== 1'b1 || ecx_out !== m_ecx || edi_out !== m_edi) begin
      n_fail++; $display("FAIL overrun_flag: ovr=%b ecx=%h edi=%h, required 1 %h %h", err_overrun, ecx_out, edi_out, m_ecx, m_edi);
    end
    @(negedge clk);
    opc = OP_MOVS; rep_kind = REP_E; width_sel = WIDTH_BYTE; ecx_in = 32'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wc = 0;
    while (!iter_valid && wc < 16) begin @(negedge clk); wc++; end
    n_checks++;
    if (!iter_valid || err_overrun !== 1'b0) begin
      n_fail++; $display("FAIL overrun_clear: valid=%b ovr=%b, required 1 0", iter_valid, err_overrun);
    end
    iter_ready = 1'b1;
    @(negedge clk);
    iter_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({iter_valid, busy, done, err_overrun} !== 4'b0 || ecx_out !== 0 || esi_out !== 0 || edi_out !== 0) begin
      n_fail++; $display("FAIL midrun_reset: valid=%b busy=%b done=%b ovr=%b ecx=%h esi=%h edi=%h, required all 0",
                         iter_valid, busy, done, err_overrun, ecx_out, esi_out, edi_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_no_done: done=%b busy=%b, required 0 0", done, busy); end
  endtask

  initial begin
    test_reset();
    test_movs_single();
    test_rep_stos();
    test_repe_cmps();
    test_zero_count();
    test_wrap_and_stall();
    test_random();
    test_overrun_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
